cntry_sensor: RTL and testbench

Country-road vehicle detector and light monitor that drives the `X` input of `sig_control`, the highway/country traffic controller. It debounces a raw loop-sensor input into car arrivals and keeps a saturating count of cars waiting on the country road. Cars leave the count at a fixed rate while the country light is GREEN. It also monitors the `hwy`/`cntry` light codes from `sig_control` and flags unsafe or illegal combinations.

---
 rtl/cntry_sensor.sv | 181 ++++++++++++++++++
 tb/tb_cntry_sensor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cntry_sensor.sv
// rtl/cntry_sensor.sv - country-road car detector, waiting-car counter and light monitor
module cntry_sensor #(
  parameter int DEBOUNCE      = 3,
  parameter int DEPART_CYCLES = 2,
  parameter int MAX_CARS      = 15,
  parameter int CNT_W         = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             car,
  input  logic [1:0]       hwy,
  input  logic [1:0]       cntry,
  output logic             X,
  output logic [CNT_W-1:0] count,
  output logic             arrive,
  output logic             depart,
  output logic             ovf,
  output logic             err
);

  localparam logic [1:0]       L_RED   = 2'd0;
  localparam logic [1:0]       L_GREEN = 2'd2;
  localparam logic [1:0]       L_ILL   = 2'd3;
  localparam logic [3:0]       DEB     = 4'(DEBOUNCE);
  localparam logic [3:0]       DEP_TOP = 4'(DEPART_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CARS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RISE    = 2'd1,
    S_PRESENT = 2'd2,
    S_FALL    = 2'd3
  } deb_state_t;

  deb_state_t       state_q, state_d;
  logic [3:0]       dcnt_q, dcnt_d;
  logic [3:0]       ptmr_q, ptmr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             x_q, x_d;
  logic             arrive_q, depart_q;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             arr_evt, dep_evt;

  // Debounce next-state: count consecutive equal samples, one arrival per PRESENT episode
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    arr_evt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (car) begin
          if (DEB == 4'd1) begin
            state_d = S_PRESENT;
            dcnt_d  = 4'd0;
            arr_evt = 1'b1;
          end else begin
            state_d = S_RISE;
            dcnt_d  = 4'd1;
          end
        end
      end
      S_RISE: begin
        if (!car) begin
          state_d = S_IDLE;
          dcnt_d  = 4'd0;
        end else if (dcnt_q + 4'd1 == DEB) begin
          state_d = S_PRESENT;
          dcnt_d  = 4'd0;
          arr_evt = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 4'd1;
        end
      end
      S_PRESENT: begin
        if (!car) begin
          if (DEB == 4'd1) begin
            state_d = S_IDLE;
            dcnt_d  = 4'd0;
          end else begin
            state_d = S_FALL;
            dcnt_d  = 4'd1;
          end
        end
      end
      S_FALL: begin
        if (car) begin
          state_d = S_PRESENT;
          dcnt_d  = 4'd0;
        end else if (dcnt_q + 4'd1 == DEB) begin
          state_d = S_IDLE;
          dcnt_d  = 4'd0;
        end else begin
          dcnt_d = dcnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        dcnt_d  = 4'd0;
      end
    endcase
  end

  // Departure timer: runs only on uninterrupted country green with cars waiting
  always_comb begin
    ptmr_d  = 4'd0;
    dep_evt = 1'b0;
    if (cntry == L_GREEN && count_q != '0) begin
      if (ptmr_q == DEP_TOP) begin
        dep_evt = 1'b1;
      end else begin
        ptmr_d = ptmr_q + 4'd1;
      end
    end
  end

  // Count update: simultaneous arrival and departure cancel out without flagging overflow
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (arr_evt && !dep_evt) begin
      if (count_q == MAX_C) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + ONE;
      end
    end else if (dep_evt && !arr_evt) begin
      count_d = count_q - ONE;
    end
    x_d = (count_d != '0);
  end

  // Light monitor: illegal codes or both directions not RED are latched as an error
  always_comb begin
    err_d = err_q;
    if (hwy == L_ILL || cntry == L_ILL || (hwy != L_RED && cntry != L_RED)) begin
      err_d = 1'b1;
    end
  end

  // Debounce FSM state register
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      dcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Counter, timer and registered outputs
  always_ff @(posedge clock) begin
    if (clear) begin
      ptmr_q   <= 4'd0;
      count_q  <= '0;
      x_q      <= 1'b0;
      arrive_q <= 1'b0;
      depart_q <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ptmr_q   <= ptmr_d;
      count_q  <= count_d;
      x_q      <= x_d;
      arrive_q <= arr_evt;
      depart_q <= dep_evt;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign X      = x_q;
  assign count  = count_q;
  assign arrive = arrive_q;
  assign depart = depart_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule

// File: tb/tb_cntry_sensor.sv
// tb/tb_cntry_sensor.sv - directed self-checking bench for cntry_sensor
module tb_cntry_sensor;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       car   = 1'b0;
  logic [1:0] hwy   = 2'd0;
  logic [1:0] cntry = 2'd0;
  logic       X;
  logic [3:0] count;
  logic       arrive;
  logic       depart;
  logic       ovf;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  cntry_sensor dut (
    .clock  (clock),
    .clear  (clear),
    .car    (car),
    .hwy    (hwy),
    .cntry  (cntry),
    .X      (X),
    .count  (count),
    .arrive (arrive),
    .depart (depart),
    .ovf    (ovf),
    .err    (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock edge, outputs sampled 1 time unit after it
  task automatic step(input logic c);
    car = c;
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1'b0);
    clear = 1'b0;
  endtask

  // three high samples register an arrival, three low samples return to IDLE
  task automatic add_car();
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_count"},  32'(count),  32'd0);
    check({tag, "_X"},      32'(X),      32'd0);
    check({tag, "_arrive"}, 32'(arrive), 32'd0);
    check({tag, "_depart"}, 32'(depart), 32'd0);
    check({tag, "_ovf"},    32'(ovf),    32'd0);
    check({tag, "_err"},    32'(err),    32'd0);
  endtask

  initial begin
    // reset state
    hwy = 2'd2; cntry = 2'd0;
    do_clear();
    check_all_zero("reset");

    // basic arrival: three high samples, then held high
    step(1'b1); check("arr_e1", 32'(arrive), 32'd0);
    step(1'b1); check("arr_e2", 32'(arrive), 32'd0);
    step(1'b1); check("arr_e3", 32'(arrive), 32'd1);
    check("arr_count", 32'(count), 32'd1);
    check("arr_X", 32'(X), 32'd1);
    step(1'b1); check("arr_hold1", 32'(arrive), 32'd0);
    step(1'b1); check("arr_hold2", 32'(arrive), 32'd0);
    check("arr_hold_count", 32'(count), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0);

    // glitch of two highs gives nothing
    do_clear();
    step(1'b1); step(1'b1);
    step(1'b0); check("glitch_arrive", 32'(arrive), 32'd0);
    step(1'b0);
    check("glitch_count", 32'(count), 32'd0);
    check("glitch_X", 32'(X), 32'd0);

    // interrupted FALL: exactly one arrival
    step(1'b1); step(1'b1);
    step(1'b1); check("fallint_arr", 32'(arrive), 32'd1);
    step(1'b0); step(1'b0);
    step(1'b1); check("fallint_noarr", 32'(arrive), 32'd0);
    step(1'b1); check("fallint_noarr2", 32'(arrive), 32'd0);
    check("fallint_count", 32'(count), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0);

    // departures at count=3 with six clocks of country green
    do_clear();
    hwy = 2'd0; cntry = 2'd0;
    add_car(); add_car(); add_car();
    check("dep_start", 32'(count), 32'd3);
    cntry = 2'd2;
    step(1'b0); check("dep_e1", 32'(depart), 32'd0);
    step(1'b0); check("dep_e2", 32'(depart), 32'd1); check("dep_c2", 32'(count), 32'd2);
    step(1'b0); check("dep_e3", 32'(depart), 32'd0);
    step(1'b0); check("dep_e4", 32'(depart), 32'd1); check("dep_c4", 32'(count), 32'd1);
    step(1'b0); check("dep_e5", 32'(depart), 32'd0); check("dep_X5", 32'(X), 32'd1);
    step(1'b0); check("dep_e6", 32'(depart), 32'd1); check("dep_c6", 32'(count), 32'd0);
    check("dep_X6", 32'(X), 32'd0);
    check("dep_err", 32'(err), 32'd0);

    // green, yellow, green: timer restarts, no departure
    cntry = 2'd0;
    add_car();
    cntry = 2'd2; step(1'b0); check("gyg_1", 32'(depart), 32'd0);
    cntry = 2'd1; step(1'b0); check("gyg_2", 32'(depart), 32'd0);
    cntry = 2'd2; step(1'b0); check("gyg_3", 32'(depart), 32'd0);
    check("gyg_count", 32'(count), 32'd1);
    cntry = 2'd0;

    // saturation and overflow
    do_clear();
    for (int i = 0; i < 15; i++) add_car();
    check("sat_count", 32'(count), 32'd15);
    check("sat_ovf0", 32'(ovf), 32'd0);
    step(1'b1); step(1'b1);
    step(1'b1); check("ovf_arrive", 32'(arrive), 32'd1);
    check("ovf_count", 32'(count), 32'd15);
    check("ovf_set", 32'(ovf), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // simultaneous arrival and departure at saturation
    do_clear();
    for (int i = 0; i < 15; i++) add_car();
    step(1'b1);
    cntry = 2'd2;
    step(1'b1); check("sim_nodep", 32'(depart), 32'd0);
    step(1'b1);
    check("sim_arrive", 32'(arrive), 32'd1);
    check("sim_depart", 32'(depart), 32'd1);
    check("sim_count", 32'(count), 32'd15);
    check("sim_ovf", 32'(ovf), 32'd0);
    cntry = 2'd0;
    for (int i = 0; i < 3; i++) step(1'b0);

    // light monitor
    do_clear();
    check("mon_init", 32'(err), 32'd0);
    hwy = 2'd2; cntry = 2'd1; step(1'b0); check("mon_set", 32'(err), 32'd1);
    hwy = 2'd0; cntry = 2'd0; step(1'b0); check("mon_sticky", 32'(err), 32'd1);
    cntry = 2'd3; step(1'b0); check("mon_ill", 32'(err), 32'd1);
    cntry = 2'd0;
    do_clear();
    check("mon_clear", 32'(err), 32'd0);
    hwy = 2'd3; step(1'b0); check("mon_hwy3", 32'(err), 32'd1);
    hwy = 2'd0;

    // clear in RISE with dcnt=2 and count=5
    do_clear();
    for (int i = 0; i < 5; i++) add_car();
    check("mid_count5", 32'(count), 32'd5);
    step(1'b1); step(1'b1);
    clear = 1'b1; step(1'b1); clear = 1'b0;
    check_all_zero("mid_clear");
    step(1'b1); check("mid_e1", 32'(arrive), 32'd0);
    step(1'b1); check("mid_e2", 32'(arrive), 32'd0);
    step(1'b1); check("mid_e3", 32'(arrive), 32'd1);
    check("mid_count", 32'(count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
